// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, datapath
// mux selects, ALUOp codes, the state enum and the bundled control word.
package mips_ctrl_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    // States that sit on the memory handshake and may stall on mem_ready.
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory bundle. master = control FSM, slave = datapath.
interface multicycle_control_fsm_if;
    import mips_ctrl_pkg::*;

    opcode_t    op;
    logic       mem_ready;
    logic       mem_req;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  op, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_op, mem_timeout
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               instr_done, illegal_op, mem_timeout
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles and flags the cycle on which the wait must be
// abandoned. Cleared whenever the FSM is not stalled.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic expire
);

    localparam bit               EN    = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(EN ? MEM_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    // Saturates at all-ones so a disabled timeout never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!waiting || expire)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign expire = EN && waiting && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: fetch/decode/execute/memory/writeback
// with a mem_ready handshake, memory-wait timeout and illegal-opcode trap.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_fsm_if.master   bus
);
    import mips_ctrl_pkg::*;

    state_t state, next;
    ctrl_t  c;
    logic   waiting, expire;

    assign waiting = is_mem_wait(state) && !bus.mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    // mem_ready is checked before expire so a same-cycle completion wins.
    always_comb begin
        c    = '0;
        next = state;
        case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALUOP_ADD;
                c.pcsrc   = PCSRC_ALU;
                if (bus.mem_ready) begin
                    c.irwrite = 1'b1;
                    c.pcwrite = 1'b1;
                    next      = S_DECODE;
                end else if (expire) begin
                    c.mem_timeout = 1'b1;
                    next          = S_FETCH;
                end
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMM_SH;
                c.aluop   = ALUOP_ADD;
                case (bus.op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXECUTE;
                    OP_BEQ:       next = S_BRANCH;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_J:         next = S_JUMP;
                    default: begin
                        c.illegal_op = 1'b1;
                        next         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
                if (bus.op == OP_LW)      next = S_MEMREAD;
                else if (bus.op == OP_SW) next = S_MEMWRITE;
                else                      next = S_FETCH;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    next = S_MEMWB;
                end else if (expire) begin
                    c.mem_timeout = 1'b1;
                    next          = S_FETCH;
                end
            end
            S_MEMWB: begin
                c.memtoreg   = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
                next         = S_FETCH;
            end
            S_MEMWRITE: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                if (bus.mem_ready) begin
                    c.instr_done = 1'b1;
                    next         = S_FETCH;
                end else if (expire) begin
                    c.mem_timeout = 1'b1;
                    next          = S_FETCH;
                end
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALUOP_FUNCT;
                next      = S_ALUWB;
            end
            S_ALUWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
                next         = S_FETCH;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_REG;
                c.aluop      = ALUOP_SUB;
                c.pcsrc      = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
                next         = S_FETCH;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
                next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
                next         = S_FETCH;
            end
            S_JUMP: begin
                c.pcsrc      = PCSRC_JUMP;
                c.pcwrite    = 1'b1;
                c.instr_done = 1'b1;
                next         = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
        if (!rst_n) c = '0;
    end

    assign bus.mem_req     = c.mem_req;
    assign bus.IorD        = c.iord;
    assign bus.MemWrite    = c.memwrite;
    assign bus.IRWrite     = c.irwrite;
    assign bus.PCWrite     = c.pcwrite;
    assign bus.Branch      = c.branch;
    assign bus.PCSrc       = c.pcsrc;
    assign bus.ALUSrcA     = c.alusrca;
    assign bus.ALUSrcB     = c.alusrcb;
    assign bus.ALUOp       = c.aluop;
    assign bus.RegDst      = c.regdst;
    assign bus.MemtoReg    = c.memtoreg;
    assign bus.RegWrite    = c.regwrite;
    assign bus.instr_done  = c.instr_done;
    assign bus.illegal_op  = c.illegal_op;
    assign bus.mem_timeout = c.mem_timeout;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle control vectors for
// each instruction class, memory stalls, timeout, illegal op and reset.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(
        .MEM_TIMEOUT (4),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {mem_req,IorD,MemWrite,IRWrite,PCWrite,Branch,PCSrc,ALUSrcA,ALUSrcB,
    //  ALUOp,RegDst,MemtoReg,RegWrite,instr_done,illegal_op,mem_timeout}
    logic [18:0] outs;
    assign outs = {bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                   bus.Branch, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                   bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.instr_done,
                   bus.illegal_op, bus.mem_timeout};

    localparam logic [18:0] V_ZERO    = 19'b0;
    localparam logic [18:0] V_FETCH   = 19'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0_0;
    localparam logic [18:0] V_FWAIT   = 19'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0_0;
    localparam logic [18:0] V_FTO     = 19'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0_1;
    localparam logic [18:0] V_DECODE  = 19'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0_0;
    localparam logic [18:0] V_DEC_ILL = 19'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_1_0;
    localparam logic [18:0] V_MEMADR  = 19'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
    localparam logic [18:0] V_MEMREAD = 19'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
    localparam logic [18:0] V_MR_TO   = 19'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0_1;
    localparam logic [18:0] V_MEMWB   = 19'b0_0_0_0_0_0_00_0_00_00_0_1_1_1_0_0;
    localparam logic [18:0] V_MW_WAIT = 19'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0_0;
    localparam logic [18:0] V_MW_DONE = 19'b1_1_1_0_0_0_00_0_00_00_0_0_0_1_0_0;
    localparam logic [18:0] V_EXECUTE = 19'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0_0;
    localparam logic [18:0] V_ALUWB   = 19'b0_0_0_0_0_0_00_0_00_00_1_0_1_1_0_0;
    localparam logic [18:0] V_BRANCH  = 19'b0_0_0_0_0_1_01_1_00_01_0_0_0_1_0_0;
    localparam logic [18:0] V_ADDIWB  = 19'b0_0_0_0_0_0_00_0_00_00_0_0_1_1_0_0;
    localparam logic [18:0] V_JUMP    = 19'b0_0_0_0_1_0_10_0_00_00_0_0_0_1_0_0;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02, OP_BAD = 6'h3F;

    task automatic test_reset();
        bit          r[5] = '{0, 0, 1, 1, 1};
        logic [18:0] e[5] = '{V_ZERO, V_ZERO, V_FETCH, V_DECODE, V_JUMP};
        for (int i = 0; i < 5; i++) begin
            rst_n = r[i]; bus.op = OP_J; bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL reset cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        logic [18:0] e[5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB};
        int done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            rst_n = 1'b1; bus.op = OP_LW; bus.mem_ready = 1'b1;
            @(negedge clk);
            done_cnt += int'(bus.instr_done);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL lw cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL lw instr_done count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_sw_stall();
        bit          m[7] = '{1, 1, 1, 0, 0, 0, 1};
        logic [18:0] e[7] = '{V_FETCH, V_DECODE, V_MEMADR, V_MW_WAIT, V_MW_WAIT,
                              V_MW_WAIT, V_MW_DONE};
        int mw_cnt = 0, rw_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            rst_n = 1'b1; bus.op = OP_SW; bus.mem_ready = m[i];
            @(negedge clk);
            mw_cnt += int'(bus.MemWrite);
            rw_cnt += int'(bus.RegWrite);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL sw cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (mw_cnt !== 4) begin
            failures++;
            $display("FAIL sw MemWrite cycles: got %0d want 4", mw_cnt);
        end
        checks++;
        if (rw_cnt !== 0) begin
            failures++;
            $display("FAIL sw RegWrite cycles: got %0d want 0", rw_cnt);
        end
    endtask

    task automatic test_rtype_addi();
        logic [5:0]  o[8] = '{OP_R, OP_R, OP_R, OP_R, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
        logic [18:0] e[8] = '{V_FETCH, V_DECODE, V_EXECUTE, V_ALUWB,
                              V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB};
        for (int i = 0; i < 8; i++) begin
            rst_n = 1'b1; bus.op = o[i]; bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL rtype_addi cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0]  o[6] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
        logic [18:0] e[6] = '{V_FETCH, V_DECODE, V_BRANCH, V_FETCH, V_DECODE, V_JUMP};
        for (int i = 0; i < 6; i++) begin
            rst_n = 1'b1; bus.op = o[i]; bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL branch_jump cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  o[6] = '{OP_BAD, OP_BAD, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
        logic [18:0] e[6] = '{V_FETCH, V_DEC_ILL, V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB};
        for (int i = 0; i < 6; i++) begin
            rst_n = 1'b1; bus.op = o[i]; bus.mem_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL illegal cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        bit          m[7] = '{0, 0, 0, 0, 1, 1, 1};
        logic [18:0] e[7] = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FTO, V_FETCH, V_DECODE, V_JUMP};
        for (int i = 0; i < 7; i++) begin
            rst_n = 1'b1; bus.op = OP_J; bus.mem_ready = m[i];
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL fetch_timeout cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_memread_timeout();
        logic [5:0]  o[10] = '{OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW,
                               OP_J, OP_J, OP_J};
        bit          m[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        logic [18:0] e[10] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD,
                               V_MEMREAD, V_MR_TO, V_FETCH, V_DECODE, V_JUMP};
        for (int i = 0; i < 10; i++) begin
            rst_n = 1'b1; bus.op = o[i]; bus.mem_ready = m[i];
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL memread_timeout cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout_race();
        bit          m[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        logic [18:0] e[8] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMREAD,
                              V_MEMREAD, V_MEMREAD, V_MEMWB};
        for (int i = 0; i < 8; i++) begin
            rst_n = 1'b1; bus.op = OP_LW; bus.mem_ready = m[i];
            @(negedge clk);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL timeout_race cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bit          r[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
        bit          m[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        logic [5:0]  o[8] = '{OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_J, OP_J, OP_J};
        logic [18:0] e[8] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_ZERO,
                              V_FETCH, V_DECODE, V_JUMP};
        int rw_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            rst_n = r[i]; bus.op = o[i]; bus.mem_ready = m[i];
            @(negedge clk);
            rw_cnt += int'(bus.RegWrite);
            checks++;
            if (outs !== e[i]) begin
                failures++;
                $display("FAIL reset_mid cycle %0d: got %b want %b", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rw_cnt !== 0) begin
            failures++;
            $display("FAIL reset_mid RegWrite cycles: got %0d want 0", rw_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.op = OP_R;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype_addi();
        test_branch_jump();
        test_illegal();
        test_fetch_timeout();
        test_memread_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, IR and PC write enables.
- Decodes the opcode from the instruction register and steps the datapath through fetch, decode, execute, memory and writeback, one state per clock.
- Handles lw, sw, R-type, beq, addi and j.
- Adds a memory wait handshake with a timeout and an illegal-opcode trap.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent waiting for mem_ready in any memory state; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  6  opcode from IR[31:26]; held stable by the IR from DECODE until the next FETCH
- mem_ready  in  1  memory has completed the current read or write this cycle
- mem_req  out  1  memory access request
- IorD  out  1  address mux select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load, ANDed with Zero in the datapath
- PCSrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded (same encoding as the ALU decoder)
- RegDst  out  1  register destination: 1 = rd, 0 = rt
- MemtoReg  out  1  register write data: 1 = memory data, 0 = ALUOut
- RegWrite  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when a memory wait is aborted

Behaviour:
- Register state updates on the rising clk edge. If rst_n = 0 at an edge: state <= FETCH, wait counter <= 0.
- While rst_n = 0, all outputs are forced to 0 combinationally.
- Any output not listed for a state is 0.
- Outputs are Moore, decoded from state. Exceptions: IRWrite, PCWrite and MemWrite completion also depend on mem_ready, as noted below.
- Opcode values: 00 = R-type, 23 = lw, 2B = sw, 04 = beq, 08 = addi, 02 = j.
- FETCH:
  - Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; then go to DECODE. Otherwise stay.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state: lw or sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode: pulse illegal_op and go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: mem_req=1, IorD=1. Go to MEMWB when mem_ready=1; otherwise stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWRITE: mem_req=1, IorD=1, MemWrite=1, held until mem_ready=1. Then instr_done=1 and go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1. Next state FETCH.
- Latency with mem_ready tied to 1, counting cycles from entering FETCH:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
- Wait counter:
  - Counts the cycles spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on leaving any of those states.
  - When MEM_TIMEOUT != 0 and counter = MEM_TIMEOUT-1 with mem_ready still 0: pulse mem_timeout, go to FETCH, and assert no IRWrite, PCWrite or RegWrite.
  - The counter saturates and never wraps.
  - If mem_ready=1 arrives in the same cycle the timeout would fire, mem_ready wins: normal completion, no mem_timeout pulse.
- Reset mid-instruction: the pending register write is dropped, and the FSM is in FETCH on the cycle after the reset edge.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the ALUOp encodings
  - the PCSrc and ALUSrcB encodings
  - the state enum typedef
- One sub-module, mem_wait_timer, contains the wait counter and timeout compare.
- The next-state logic and output decode stay in the top-level module.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then released with mem_ready=1 → every output is 0 during reset; mem_req=1 and IRWrite=1 in the first cycle after release.
- lw (op=23), mem_ready=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with MemtoReg=1 in cycle 5; instr_done pulses exactly once.
- sw (op=2B) with mem_ready low for 3 cycles in MEMWRITE → MemWrite held high for 4 cycles; no RegWrite at any point; 7 cycles total.
- beq (op=04) then j (op=02) → BRANCH asserts ALUOp=01, PCSrc=01, Branch=1; JUMP asserts PCSrc=10, PCWrite=1; each instruction takes 3 cycles.
- Illegal op=3F → illegal_op pulses in DECODE and the FSM is back in FETCH on the next cycle; MEM_TIMEOUT=4 with mem_ready=0 in FETCH → mem_timeout pulses in the 4th wait cycle and IRWrite never asserts.
- rst_n driven to 0 while in MEMREAD → no RegWrite; FSM in FETCH after the edge. mem_ready=1 on the exact timeout cycle → normal completion, no mem_timeout pulse.
